// File: rtl/boot_reset_sequencer.sv
// Power-up reset sequencer: stabilization wait, then ordered per-stage reset release with ACK handshake.
// Optional per-stage ACK timeout / FAULT state enabled by defining BOOT_SEQ_TIMEOUT_EN.
module boot_reset_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int STABLE_CYCLES = 64,
  parameter int ACK_TIMEOUT   = 1024,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  START,
  input  logic [NUM_STAGES-1:0] ACK,
  output logic [NUM_STAGES-1:0] RST_N_OUT,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [SW-1:0]         ERR_STAGE
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STABLE, S_WAIT_ACK, S_DONE, S_FAULT
  } state_t;

  state_t        state;
  logic [SW-1:0] stg;
  logic [CW-1:0] scnt;

`ifdef BOOT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign ERROR     = 1'b0;
  assign ERR_STAGE = '0;
`endif

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state     <= S_IDLE;
      stg       <= '0;
      scnt      <= '0;
      RST_N_OUT <= '0;
      DONE      <= 1'b0;
`ifdef BOOT_SEQ_TIMEOUT_EN
      tcnt      <= '0;
      ERROR     <= 1'b0;
      ERR_STAGE <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_STABLE;
            scnt  <= '0;
            stg   <= '0;
          end
        end
        S_STABLE: begin
          if (!START) begin
            state     <= S_IDLE;
            RST_N_OUT <= '0;
          end else if (scnt == CW'(STABLE_CYCLES - 1)) begin
            state     <= S_WAIT_ACK;
            stg       <= '0;
            RST_N_OUT <= NUM_STAGES'(1);
`ifdef BOOT_SEQ_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          // Abort has priority over both ACK acceptance and timeout.
          if (!START) begin
            state     <= S_IDLE;
            RST_N_OUT <= '0;
            stg       <= '0;
          end else if (ACK[stg]) begin
            if (stg == SW'(NUM_STAGES - 1)) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else begin
              // Stages release in order, so RST_N_OUT is a thermometer code.
              stg       <= stg + 1'b1;
              RST_N_OUT <= NUM_STAGES'({RST_N_OUT, 1'b1});
`ifdef BOOT_SEQ_TIMEOUT_EN
              tcnt      <= '0;
`endif
            end
          end
`ifdef BOOT_SEQ_TIMEOUT_EN
          else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            state     <= S_FAULT;
            RST_N_OUT <= '0;
            ERROR     <= 1'b1;
            ERR_STAGE <= stg;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (!START) begin
            state     <= S_IDLE;
            RST_N_OUT <= '0;
            DONE      <= 1'b0;
          end
        end
        S_FAULT: begin
          RST_N_OUT <= '0;
        end
        default: begin
          state     <= S_IDLE;
          RST_N_OUT <= '0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Directed bench for boot_reset_sequencer (NUM_STAGES=3, STABLE_CYCLES=8, ACK_TIMEOUT=16, 25 ns clock).
`timescale 1ns/100ps
module tb_boot_reset_sequencer;

  logic       C = 1'b0;
  logic       R;
  logic       START;
  logic [2:0] ACK;
  logic [2:0] RST_N_OUT;
  logic       DONE;
  logic       ERROR;
  logic [1:0] ERR_STAGE;

  int checks = 0;
  int errors = 0;

  boot_reset_sequencer #(
    .NUM_STAGES(3), .STABLE_CYCLES(8), .ACK_TIMEOUT(16)
  ) dut (
    .C(C), .R(R), .START(START), .ACK(ACK),
    .RST_N_OUT(RST_N_OUT), .DONE(DONE), .ERROR(ERROR), .ERR_STAGE(ERR_STAGE)
  );

  always #12.5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] rst, input logic done,
                            input logic err, input logic [1:0] es);
    chk({tag, ".rst"}, 32'(RST_N_OUT), 32'(rst));
    chk({tag, ".done"}, 32'(DONE), 32'(done));
    chk({tag, ".err"}, 32'(ERROR), 32'(err));
    chk({tag, ".es"}, 32'(ERR_STAGE), 32'(es));
  endtask

  // Advance n active edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  initial begin
    R = 1'b0; START = 1'b0; ACK = 3'b000;
    #1;
    expect_out("reset_pre_clk", 3'b000, 1'b0, 1'b0, 2'd0);
    step(2);
    R = 1'b1;
    step(1);
    expect_out("reset_idle", 3'b000, 1'b0, 1'b0, 2'd0);

    // Handshake with ACK two cycles after each release
    START = 1'b1;
    step(8);
    expect_out("hs_e7", 3'b000, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("hs_e8", 3'b001, 1'b0, 1'b0, 2'd0);
    step(1); ACK = 3'b001;
    step(1);
    expect_out("hs_e10", 3'b011, 1'b0, 1'b0, 2'd0);
    step(1); ACK = 3'b011;
    step(1);
    expect_out("hs_e12", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1); ACK = 3'b111;
    expect_out("hs_e13", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("hs_e14", 3'b111, 1'b1, 1'b0, 2'd0);
    step(3);
    expect_out("hs_hold", 3'b111, 1'b1, 1'b0, 2'd0);
    START = 1'b0;
    step(1);
    expect_out("hs_stop", 3'b000, 1'b0, 1'b0, 2'd0);

    // ACK all-ones before START: one stage per cycle
    ACK = 3'b111; START = 1'b1;
    step(9);
    expect_out("fast_e8", 3'b001, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("fast_e9", 3'b011, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("fast_e10", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("fast_e11", 3'b111, 1'b1, 1'b0, 2'd0);
    START = 1'b0;
    step(1);

    // ACK[1] withheld
    ACK = 3'b101; START = 1'b1;
    step(9);
    expect_out("to_e8", 3'b001, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("to_e9", 3'b011, 1'b0, 1'b0, 2'd0);
    step(15);
    expect_out("to_e24", 3'b011, 1'b0, 1'b0, 2'd0);
    step(1);
`ifdef BOOT_SEQ_TIMEOUT_EN
    expect_out("to_e25_fault", 3'b000, 1'b0, 1'b1, 2'd1);
    START = 1'b0;
    step(2);
    expect_out("to_sticky_lo", 3'b000, 1'b0, 1'b1, 2'd1);
    START = 1'b1; ACK = 3'b111;
    step(10);
    expect_out("to_sticky_hi", 3'b000, 1'b0, 1'b1, 2'd1);
    #2 R = 1'b0;
    #1;
    expect_out("to_rpulse", 3'b000, 1'b0, 1'b0, 2'd0);
    START = 1'b0;
    #2 R = 1'b1;
    step(1);
`else
    expect_out("to_e25_nofault", 3'b011, 1'b0, 1'b0, 2'd0);
    step(75);
    expect_out("to_e100", 3'b011, 1'b0, 1'b0, 2'd0);
    ACK = 3'b111;
    step(1);
    expect_out("to_late_ack", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("to_late_done", 3'b111, 1'b1, 1'b0, 2'd0);
    START = 1'b0;
    step(1);
`endif
    expect_out("to_after", 3'b000, 1'b0, 1'b0, 2'd0);

    // ACK[1] arrives exactly at the timeout edge
    ACK = 3'b101; START = 1'b1;
    step(10);
    expect_out("edge_e9", 3'b011, 1'b0, 1'b0, 2'd0);
    step(15);
    ACK = 3'b111;
    step(1);
    expect_out("edge_e25", 3'b111, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("edge_e26", 3'b111, 1'b1, 1'b0, 2'd0);
    START = 1'b0;
    step(1);

    // Abort in WAIT_ACK stage 1, then full restart
    ACK = 3'b001; START = 1'b1;
    step(10);
    expect_out("ab_e9", 3'b011, 1'b0, 1'b0, 2'd0);
    step(2);
    START = 1'b0;
    step(1);
    expect_out("ab_idle", 3'b000, 1'b0, 1'b0, 2'd0);
    ACK = 3'b111; START = 1'b1;
    step(8);
    expect_out("ab_re_e7", 3'b000, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("ab_re_e8", 3'b001, 1'b0, 1'b0, 2'd0);
    START = 1'b0;  // ACK[0] high on the same edge: abort wins
    step(1);
    expect_out("ab_vs_ack", 3'b000, 1'b0, 1'b0, 2'd0);

    // Async reset mid-STABLE restarts the wait from scratch
    START = 1'b1;
    step(4);
    #2 R = 1'b0;
    #1;
    expect_out("r_stable", 3'b000, 1'b0, 1'b0, 2'd0);
    #2 R = 1'b1;
    step(8);
    expect_out("r_re_e7", 3'b000, 1'b0, 1'b0, 2'd0);
    step(1);
    expect_out("r_re_e8", 3'b001, 1'b0, 1'b0, 2'd0);
    step(3);
    expect_out("r_done", 3'b111, 1'b1, 1'b0, 2'd0);
    #2 R = 1'b0;
    #1;
    expect_out("r_in_done", 3'b000, 1'b0, 1'b0, 2'd0);
    START = 1'b0;
    #2 R = 1'b1;
    step(2);
    expect_out("r_final", 3'b000, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
